// File: rtl/psum_expander.sv
// Re-expands a truncated psum word into the 2*DATA_WIDTH accumulator domain.
// Two-stage valid/ready pipeline: stage 1 extends and clamps the offset, stage 2 shifts.
module psum_expander #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = $clog2(DATA_WIDTH),
    parameter bit SIGNED     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [SEL_WIDTH:0]        in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [2*DATA_WIDTH-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      err_clr,
    output logic                      sel_err,
    output logic                      busy
);

    localparam logic [SEL_WIDTH:0] SEL_MAX = (SEL_WIDTH+1)'(DATA_WIDTH);

    logic                    r_s1_valid;
    logic [2*DATA_WIDTH-1:0] r_ext;
    logic [SEL_WIDTH:0]      r_sel;
    logic                    r_s2_valid;
    logic [2*DATA_WIDTH-1:0] r_out;
    logic                    r_sel_err;

    logic                    w_s2_free;
    logic                    w_accept;
    logic                    w_sel_bad;
    logic                    w_sign;

    // Stage 2 can take a new word if empty or its word leaves this cycle.
    assign w_s2_free = !r_s2_valid || out_ready;
    assign in_ready  = !reset && (!r_s1_valid || w_s2_free);
    assign w_accept  = in_valid && in_ready;
    assign w_sel_bad = in_sel > SEL_MAX;
    assign w_sign    = SIGNED & in_data[DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_ext      <= '0;
            r_sel      <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_ext      <= {{DATA_WIDTH{w_sign}}, in_data};
            r_sel      <= w_sel_bad ? SEL_MAX : in_sel;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_out      <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= r_ext << r_sel;
            end
        end
    end

    // A new out-of-range accept takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_bad) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_s2_valid;
    assign sel_err   = r_sel_err;
    assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_psum_expander.sv
// Directed and randomized round-trip bench for psum_expander.
// A zero-extending instance shares all inputs with the signed one.
module tb_psum_expander;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic [4:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_clr;
    logic        sel_err;
    logic        busy;

    logic        u_in_ready;
    logic [31:0] u_out_data;
    logic        u_out_valid;
    logic        u_sel_err;
    logic        u_busy;

    int total = 0;
    int bad   = 0;

    psum_expander #(.DATA_WIDTH(16), .SIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .err_clr(err_clr),
        .sel_err(sel_err), .busy(busy)
    );

    psum_expander #(.DATA_WIDTH(16), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(u_in_ready), .out_data(u_out_data),
        .out_valid(u_out_valid), .out_ready(out_ready), .err_clr(err_clr),
        .sel_err(u_sel_err), .busy(u_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_sel = 5'd3;
        out_ready = 1'b1; err_clr = 1'b0;
        step(); step(); #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++; $display("FAIL reset_out got valid=%b data=%h exp 0/0", out_valid, out_data);
        end
        total++;
        if (sel_err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_flags got sel_err=%b busy=%b exp 0/0", sel_err, busy);
        end
        in_valid = 1'b0;
        step();
        reset = 1'b0; #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_word(input logic [15:0] d, input logic [4:0] s,
                             input logic [31:0] exp_s, input logic [31:0] exp_u);
        step();
        in_valid = 1'b1; in_data = d; in_sel = s; out_ready = 1'b1; err_clr = 1'b0; #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL word_in_ready d=%h got=%b exp=1", d, in_ready); end
        step();
        in_valid = 1'b0; #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL word_early_valid d=%h got=%b exp=0", d, out_valid); end
        step(); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_s) begin
            bad++; $display("FAIL word_signed d=%h sel=%0d got valid=%b data=%h exp 1/%h", d, s, out_valid, out_data, exp_s);
        end
        total++;
        if (u_out_valid !== 1'b1 || u_out_data !== exp_u) begin
            bad++; $display("FAIL word_unsigned d=%h sel=%0d got valid=%b data=%h exp 1/%h", d, s, u_out_valid, u_out_data, exp_u);
        end
        step(); #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL word_drain got valid=%b busy=%b exp 0/0", out_valid, busy);
        end
    endtask

    task automatic test_basic();
        test_word(16'h8001, 5'd4, 32'hFFF80010, 32'h00080010);
        total++;
        if (sel_err !== 1'b0) begin bad++; $display("FAIL basic_sel_err got=%b exp=0", sel_err); end
        test_word(16'h7FFF, 5'd16, 32'h7FFF0000, 32'h7FFF0000);
        test_word(16'hFFFF, 5'd0, 32'hFFFFFFFF, 32'h0000FFFF);
    endtask

    task automatic test_sel_err();
        bit held_ok;
        step();
        in_valid = 1'b1; in_data = 16'h0001; in_sel = 5'd20; out_ready = 1'b1;
        step();
        in_valid = 1'b0; #1;
        total++;
        if (sel_err !== 1'b1) begin bad++; $display("FAIL sel_err_set got=%b exp=1", sel_err); end
        step(); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h00010000) begin
            bad++; $display("FAIL sel_err_clamp got valid=%b data=%h exp 1/00010000", out_valid, out_data);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            if (sel_err !== 1'b1) held_ok = 1'b0;
        end
        total++;
        if (!held_ok) begin bad++; $display("FAIL sel_err_sticky got=%b exp=1", sel_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0; #1;
        total++;
        if (sel_err !== 1'b0) begin bad++; $display("FAIL sel_err_clear got=%b exp=0", sel_err); end
        in_valid = 1'b1; in_sel = 5'd20; err_clr = 1'b1;
        step();
        in_valid = 1'b0; err_clr = 1'b0; #1;
        total++;
        if (sel_err !== 1'b1) begin bad++; $display("FAIL sel_err_set_wins got=%b exp=1", sel_err); end
        step(); step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int outc = 0;
        bit busy_ok = 1'b1;
        bit stall_ok = 1'b1;
        for (int c = 0; c < 40 && outc < 4; c++) begin
            step();
            out_ready = (c >= 6);
            in_valid  = (acc < 4);
            in_data   = 16'(acc + 1);
            in_sel    = 5'd1;
            #1;
            if (c == 2) begin
                total++;
                if (in_ready !== 1'b0 || acc != 2) begin
                    bad++; $display("FAIL bp_in_ready_fall got ready=%b accepts=%0d exp 0/2", in_ready, acc);
                end
            end
            if (c >= 1 && busy !== 1'b1) busy_ok = 1'b0;
            if (c >= 2 && c < 6 && (out_valid !== 1'b1 || out_data !== 32'h2)) stall_ok = 1'b0;
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== 32'((outc + 1) * 2)) begin
                    bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", outc, out_data, 32'((outc + 1) * 2));
                end
                outc++;
            end
            if (in_valid && in_ready) acc++;
        end
        total++;
        if (outc != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", outc); end
        total++;
        if (!busy_ok) begin bad++; $display("FAIL bp_busy got=0 exp=1"); end
        total++;
        if (!stall_ok) begin bad++; $display("FAIL bp_stall_hold got valid=%b data=%h exp 1/00000002", out_valid, out_data); end
        in_valid = 1'b0;
        step(); #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_idle got busy=%b valid=%b exp 0/0", busy, out_valid);
        end
    endtask

    task automatic test_reset_flush();
        bit quiet = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0005; in_sel = 5'd0;
        step();
        in_data = 16'h0006;
        step();
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL flush got valid=%b busy=%b exp 0/0", out_valid, busy);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL flush_emit got valid=1 exp=0"); end
    endtask

    task automatic test_round_trip();
        logic [15:0] qd[$];
        logic [4:0]  qs[$];
        logic [15:0] d = '0;
        logic [4:0]  s = '0;
        logic [31:0] sh;
        logic [15:0] ed;
        logic [4:0]  es;
        bit pend = 1'b0;
        int sent = 0;
        int rcv = 0;
        int errs = 0;
        for (int c = 0; c < 20000 && rcv < 1000; c++) begin
            step();
            if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                d = 16'($urandom);
                s = 5'($urandom_range(0, 16));
                pend = 1'b1;
            end
            in_valid = pend; in_data = d; in_sel = s;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (qd.size() == 0) begin
                    errs++;
                    $display("FAIL rt_unexpected got=%h exp=no output", out_data);
                end else begin
                    ed = qd.pop_front();
                    es = qs.pop_front();
                    sh = out_data >> es;
                    if (sh[15:0] !== ed) begin
                        errs++;
                        $display("FAIL rt_word idx=%0d sel=%0d got=%h exp=%h", rcv, es, sh[15:0], ed);
                    end
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                qd.push_back(d);
                qs.push_back(s);
                pend = 1'b0;
                sent++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (errs != 0) begin bad++; $display("FAIL rt_data got=%0d errors exp=0", errs); end
        total++;
        if (rcv != 1000) begin bad++; $display("FAIL rt_count got=%0d exp=1000", rcv); end
        total++;
        if (sel_err !== 1'b0) begin bad++; $display("FAIL rt_sel_err got=%b exp=0", sel_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel_err();
        test_backpressure();
        test_reset_flush();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
